// File: rtl/msk_stream_checker.sv
// msk_stream_checker: recombines d-share masked DUT beats and compares them, in order,
// against expected values queued in a small FIFO; tracks pass/fail counts and the first failure.
module msk_stream_checker #(
   parameter int          d         = 2,
   parameter int          W         = 128,
   parameter int          DEPTH     = 4,
   parameter int          BP_MODE   = 0,
   parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           exp_valid,
   output logic           exp_ready,
   input  logic [W-1:0]   exp_data,
   input  logic           dut_valid,
   output logic           dut_ready,
   input  logic [d*W-1:0] dut_shares,
   output logic [31:0]    pass_cnt,
   output logic [31:0]    fail_cnt,
   output logic           error,
   output logic [31:0]    first_fail_idx,
   output logic           result_valid
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0]  lfsr_q, lfsr_d, pass_q, pass_d, fail_q, fail_d;
   logic [31:0]  idx_q, idx_d, idx_p_q, idx_p_d, ffi_q, ffi_d;
   logic [W-1:0] rec, rec_q, rec_d, exp_q, exp_d;
   logic         vld_q, vld_d, err_q, err_d;
   logic         empty, full, bp_ok, rdy_e, rdy_d, push, acc, match, mis;

   assign empty        = wr_ptr_q == rd_ptr_q;
   assign full         = wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]};
   assign bp_ok        = (BP_MODE == 0) || lfsr_q[0];
   assign rdy_e        = ~full & ~clear;
   assign rdy_d        = bp_ok & ~empty & ~clear;
   // Ready outputs are forced low for the whole time reset is held, not just after an edge.
   assign exp_ready    = rst_n & rdy_e;
   assign dut_ready    = rst_n & rdy_d;
   assign push         = exp_valid & rdy_e;
   assign acc          = dut_valid & rdy_d;
   assign result_valid = vld_q & ~clear;
   assign match        = rec_q == exp_q;
   assign mis          = result_valid & ~match;

   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign error          = err_q;
   assign first_fail_idx = ffi_q;

   always_comb begin
      rec = '0;
      for (int i = 0; i < d; i++) rec ^= dut_shares[i*W +: W];
   end

   always_comb begin
      lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
      wr_ptr_d = clear ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = clear ? '0 : rd_ptr_q + {{AW{1'b0}}, acc};
      vld_d    = acc;
      rec_d    = acc ? rec : rec_q;
      exp_d    = acc ? mem_q[rd_ptr_q[AW-1:0]] : exp_q;
      idx_p_d  = acc ? idx_q : idx_p_q;
      idx_d    = clear ? '0 : idx_q + {31'b0, acc};
      pass_d   = clear ? '0 : pass_q + {31'b0, result_valid & match & ~&pass_q};
      fail_d   = clear ? '0 : fail_q + {31'b0, mis & ~&fail_q};
      err_d    = ~clear & (err_q | mis);
      ffi_d    = clear ? '0 : (mis & ~err_q) ? idx_p_q : ffi_q;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= exp_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q   <= SEED;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= 1'b0;
         rec_q    <= '0;
         exp_q    <= '0;
         idx_p_q  <= '0;
         idx_q    <= '0;
         pass_q   <= '0;
         fail_q   <= '0;
         err_q    <= 1'b0;
         ffi_q    <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
         rec_q    <= rec_d;
         exp_q    <= exp_d;
         idx_p_q  <= idx_p_d;
         idx_q    <= idx_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         err_q    <= err_d;
         ffi_q    <= ffi_d;
      end
   end
endmodule

// File: tb/tb_msk_stream_checker.sv
// tb_msk_stream_checker: directed vector table, reset/clear corner cases, random stream
// against a queue-based model, and LFSR back-pressure run on a second instance.
module tb_msk_stream_checker;
   localparam logic [127:0] K = 128'h3AD77BB40D7A3660A89ECAF32466EF97;

   logic         clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
   logic         ev0 = 0, dv0 = 0, ev1 = 0, dv1 = 0;
   logic [127:0] ed0 = '0, ed1 = '0;
   logic [255:0] ds0 = '0, ds1 = '0;
   logic         er0, dr0, err0, rv0, er1, dr1, err1, rv1;
   logic [31:0]  pc0, fc0, ffi0, pc1, fc1, ffi1;
   int           checks = 0, errors = 0;

   always #5 clk = ~clk;

   msk_stream_checker #(.d(2), .W(128), .DEPTH(4), .BP_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .exp_valid(ev0), .exp_ready(er0), .exp_data(ed0),
      .dut_valid(dv0), .dut_ready(dr0), .dut_shares(ds0), .pass_cnt(pc0), .fail_cnt(fc0),
      .error(err0), .first_fail_idx(ffi0), .result_valid(rv0));

   msk_stream_checker #(.d(2), .W(128), .DEPTH(4), .BP_MODE(1), .LFSR_SEED(32'h1)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .exp_valid(ev1), .exp_ready(er1), .exp_data(ed1),
      .dut_valid(dv1), .dut_ready(dr1), .dut_shares(ds1), .pass_cnt(pc1), .fail_cnt(fc1),
      .error(err1), .first_fail_idx(ffi1), .result_valid(rv1));

   typedef struct {
      bit ev, dv, clr, bad, er, dr, rv, err;
      int pc, fc, ffi;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(bit ev, bit dv, bit clr, bit bad, bit er, bit dr, bit rv,
                               int pc, int fc, bit err, int ffi);
      vec_t v;
      v.ev = ev; v.dv = dv; v.clr = clr; v.bad = bad; v.er = er; v.dr = dr; v.rv = rv;
      v.pc = pc; v.fc = fc; v.err = err; v.ffi = ffi;
      return v;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] pv(int n);
      return K ^ 128'(n);
   endfunction

   function automatic logic [127:0] fv(int n);
      return {32'(n), ~32'(n), 32'(n) ^ 32'hA5A5A5A5, 32'h12345678};
   endfunction

   // Right-shifting Galois form of x^32+x^22+x^2+x+1.
   function automatic logic [31:0] lfsr_step(logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_er0"}, er0, 0);   chk({tag, "_dr0"}, dr0, 0);
      chk({tag, "_rv0"}, rv0, 0);   chk({tag, "_pc0"}, pc0, 0);
      chk({tag, "_fc0"}, fc0, 0);   chk({tag, "_err0"}, err0, 0);
      chk({tag, "_ffi0"}, ffi0, 0); chk({tag, "_er1"}, er1, 0);
      chk({tag, "_dr1"}, dr1, 0);   chk({tag, "_pc1"}, pc1, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; clear = 0; ev0 = 0; dv0 = 0; ev1 = 0; dv1 = 0;
      #1 chk_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int np, nb;
      logic [127:0] r, head, tgt, ed;
      logic [127:0] q[$];
      bit pv_v, pv_m, e_er, e_dr, pop, push, clr, bad;
      int pv_i, mpc, mfc, mffi, bi, sz, nacc, npush;
      bit merr;
      logic [31:0] g;

      tbl[0]  = mk(0,1,0,0, 1,0,0, 0,0,0,0);
      tbl[1]  = mk(1,0,0,0, 1,0,0, 0,0,0,0);
      tbl[2]  = mk(0,1,0,0, 1,1,0, 0,0,0,0);
      tbl[3]  = mk(0,0,0,0, 1,0,1, 0,0,0,0);
      tbl[4]  = mk(0,0,0,0, 1,0,0, 1,0,0,0);
      tbl[5]  = mk(1,0,0,0, 1,0,0, 1,0,0,0);
      tbl[6]  = mk(1,1,0,0, 1,1,0, 1,0,0,0);
      tbl[7]  = mk(1,1,0,1, 1,1,1, 1,0,0,0);
      tbl[8]  = mk(0,1,0,0, 1,1,1, 2,0,0,0);
      tbl[9]  = mk(0,0,0,0, 1,0,1, 2,1,1,2);
      tbl[10] = mk(0,0,0,0, 1,0,0, 3,1,1,2);
      tbl[11] = mk(1,0,0,0, 1,0,0, 3,1,1,2);
      tbl[12] = mk(1,0,0,0, 1,1,0, 3,1,1,2);
      tbl[13] = mk(1,0,0,0, 1,1,0, 3,1,1,2);
      tbl[14] = mk(1,0,0,0, 1,1,0, 3,1,1,2);
      tbl[15] = mk(0,0,0,0, 0,1,0, 3,1,1,2);
      tbl[16] = mk(0,1,0,0, 0,1,0, 3,1,1,2);
      tbl[17] = mk(1,1,1,0, 0,0,0, 3,1,1,2);
      tbl[18] = mk(0,0,0,0, 1,0,0, 0,0,0,0);
      tbl[19] = mk(0,0,0,0, 1,0,0, 0,0,0,0);

      #1 chk_reset_vals("init");
      @(negedge clk);
      rst_n = 1'b1;

      np = 0; nb = 0;
      foreach (tbl[i]) begin
         r = rnd128();
         ev0 = tbl[i].ev; ed0 = pv(np); dv0 = tbl[i].dv; clear = tbl[i].clr;
         ds0 = {r ^ pv(nb) ^ 128'(tbl[i].bad), r};
         #1;
         chk($sformatf("t%0d_er", i), er0, tbl[i].er);
         chk($sformatf("t%0d_dr", i), dr0, tbl[i].dr);
         chk($sformatf("t%0d_rv", i), rv0, tbl[i].rv);
         chk($sformatf("t%0d_pc", i), pc0, tbl[i].pc);
         chk($sformatf("t%0d_fc", i), fc0, tbl[i].fc);
         chk($sformatf("t%0d_err", i), err0, tbl[i].err);
         chk($sformatf("t%0d_ffi", i), ffi0, tbl[i].ffi);
         if (tbl[i].ev && tbl[i].er) np++;
         if (tbl[i].dv && tbl[i].dr) nb++;
         if (tbl[i].clr) begin np = 0; nb = 0; end
         @(negedge clk);
      end
      ev0 = 0; dv0 = 0; clear = 0;

      // Reset pulse while a beat is in flight.
      r = rnd128();
      ev0 = 1; ed0 = pv(0);
      @(negedge clk);
      ed0 = pv(1); dv0 = 1; ds0 = {r ^ pv(0), r};
      @(negedge clk);
      ev0 = 0; ds0 = {r ^ pv(1), r};
      #1 chk("mid_rv_pre", rv0, 1);
      @(negedge clk);
      dv0 = 0;
      #1 chk("mid_pc_pre", pc0, 1);
      chk("mid_rv_pre2", rv0, 1);
      #1 rst_n = 1'b0;
      #1 chk("async_er", er0, 0); chk("async_dr", dr0, 0); chk("async_rv", rv0, 0);
      chk("async_pc", pc0, 0); chk("async_err", err0, 0); chk("async_ffi", ffi0, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      #1 chk("rel_er", er0, 1); chk("rel_dr", dr0, 0); chk("rel_rv", rv0, 0); chk("rel_pc", pc0, 0);
      ev0 = 1; ed0 = pv(0);
      @(negedge clk);
      ev0 = 0; dv0 = 1; ds0 = {r ^ pv(0), r};
      #1 chk("rel_dr2", dr0, 1);
      @(negedge clk);
      dv0 = 0;
      @(negedge clk);
      #1 chk("rel_pc2", pc0, 1); chk("rel_err2", err0, 0);

      // Random stream against a queue model.
      do_reset();
      q.delete(); pv_v = 0; pv_m = 0; pv_i = 0; mpc = 0; mfc = 0; merr = 0; mffi = 0; bi = 0;
      for (int c = 0; c < 600; c++) begin
         clr = ($urandom_range(0, 39) == 0);
         bad = ($urandom_range(0, 7) == 0);
         ed  = rnd128();
         r   = rnd128();
         head = (q.size() > 0) ? q[0] : rnd128();
         tgt = head ^ (bad ? (128'h1 << $urandom_range(0, 127)) : 128'h0);
         clear = clr; ev0 = 1'($urandom_range(0, 1)); ed0 = ed;
         dv0 = 1'($urandom_range(0, 1)); ds0 = {r ^ tgt, r};
         #1;
         e_er = !clr && q.size() < 4;
         e_dr = !clr && q.size() > 0;
         chk("rnd_er", er0, e_er);
         chk("rnd_dr", dr0, e_dr);
         chk("rnd_rv", rv0, pv_v && !clr);
         chk("rnd_pc", pc0, mpc);
         chk("rnd_fc", fc0, mfc);
         chk("rnd_err", err0, merr);
         chk("rnd_ffi", ffi0, mffi);
         if (clr) begin
            q.delete(); pv_v = 0; mpc = 0; mfc = 0; merr = 0; mffi = 0; bi = 0;
         end else begin
            if (pv_v) begin
               if (pv_m) mpc++;
               else begin
                  mfc++;
                  if (!merr) mffi = pv_i;
                  merr = 1;
               end
            end
            pv_v = dv0 && e_dr;
            if (pv_v) begin
               pv_m = (tgt == q[0]);
               pv_i = bi++;
               void'(q.pop_front());
            end
            if (ev0 && e_er) q.push_back(ed);
         end
         @(negedge clk);
      end
      clear = 0; ev0 = 0; dv0 = 0;

      // LFSR back-pressure: 1000 matching beats with exp side always offering data.
      do_reset();
      g = 32'h1; sz = 0; nacc = 0; npush = 0;
      r = rnd128();
      for (int c = 0; c < 6000 && nacc < 1000; c++) begin
         ev1 = 1; ed1 = fv(npush); dv1 = 1; ds1 = {r ^ fv(nacc), r};
         #1;
         e_dr = g[0] && sz > 0;
         chk("bp_ready", dr1, e_dr);
         pop = e_dr; push = sz < 4;
         if (push) npush++;
         if (pop) nacc++;
         sz = sz + int'(push) - int'(pop);
         g = lfsr_step(g);
         @(negedge clk);
      end
      ev1 = 0; dv1 = 0;
      chk("bp_beats", nacc, 1000);
      repeat (3) @(negedge clk);
      chk("bp_pc", pc1, 1000);
      chk("bp_fc", fc1, 0);
      chk("bp_err", err1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
